// File: rtl/mil_line_encoder.sv
// MIL-STD-1553 Manchester II transmit encoder: sync, 16 data bits MSB first, odd parity,
// driven onto a differential pair that idles at 0/0.
module mil_line_encoder #(
  parameter int CLK_PER_HALFBIT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iStart,
  input  logic        iCmdSync,
  input  logic [15:0] iData,
  output logic        oReady,
  output logic        oBusy,
  output logic        oDone,
  output logic        oLineP,
  output logic        oLineN
);

  localparam int DW = (CLK_PER_HALFBIT > 2) ? $clog2(CLK_PER_HALFBIT) : 1;
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_PER_HALFBIT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  state_t        state, nState;
  logic [DW-1:0] div, nDiv;
  logic [5:0]    hb, nHb;
  logic [16:0]   shift, nShift;
  logic          cmdSync, nCmdSync;
  logic          nLevel, nActive;
  logic          lastDiv, wordEnd, accept;

  assign lastDiv = (div == LAST_DIV);
  assign wordEnd = (state == PARITY) && (hb == 6'd39) && lastDiv;
  assign oReady  = ~rst & ((state == IDLE) | wordEnd);
  assign oBusy   = (state != IDLE);
  assign oDone   = ~rst & wordEnd;
  assign accept  = iStart & oReady;

  // Next-state view of the frame; the line level is derived from it so the
  // registered outputs show each half-bit in the same cycle as its counters.
  always_comb begin
    nState   = state;
    nDiv     = div;
    nHb      = hb;
    nShift   = shift;
    nCmdSync = cmdSync;
    if (state == IDLE || wordEnd) begin
      if (accept) begin
        nState   = SYNC;
        nDiv     = '0;
        nHb      = 6'd0;
        nShift   = {iData, ~^iData};
        nCmdSync = iCmdSync;
      end else if (wordEnd) begin
        nState = IDLE;
        nDiv   = '0;
        nHb    = 6'd0;
      end
    end else if (!lastDiv) begin
      nDiv = div + 1'b1;
    end else begin
      nDiv = '0;
      nHb  = hb + 6'd1;
      if (hb[0] && hb >= 6'd7)
        nShift = {shift[15:0], 1'b0};
      if (hb == 6'd5)
        nState = DATA;
      else if (hb == 6'd37)
        nState = PARITY;
    end

    nActive = (nState != IDLE);
    nLevel  = 1'b0;
    case (nState)
      SYNC:        nLevel = nCmdSync ? (nHb < 6'd3) : (nHb >= 6'd3);
      DATA, PARITY: nLevel = nShift[16] ^ nHb[0];
      default:     nLevel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      hb      <= 6'd0;
      shift   <= 17'd0;
      cmdSync <= 1'b0;
      oLineP  <= 1'b0;
      oLineN  <= 1'b0;
    end else begin
      state   <= nState;
      div     <= nDiv;
      hb      <= nHb;
      shift   <= nShift;
      cmdSync <= nCmdSync;
      oLineP  <= nActive & nLevel;
      oLineN  <= nActive & ~nLevel;
    end
  end

endmodule
